sa_cache_mem_ctrl: RTL and testbench
====================================

// Module: sa_cache_mem_ctrl
// PURPOSE
//  Memory-side companion of sa_cache, sitting directly downstream of it.
//  - Consumes cache misses and evictions from sa_cache.
//  - Buffers evicted words in a small write-back FIFO.
//  - Issues reads and writes to backing memory over a req/ack handshake.
//  - Returns fill data to sa_cache on i_memory_line, with a one-cycle
//    i_memory_response pulse.
// PARAMETERS
//  ADDR_W    32  address width; equals TAG_W+INDEX_W+OFFSET_W
//  DATA_W    32  word / line width
//  TAG_W     18  tag width
//  INDEX_W    8  index width
//  OFFSET_W   6  offset width
//  WB_DEPTH   4  write-back FIFO entries (power of 2, >=2)
// PORTS
//  clk              in   1        clock, all logic on posedge
//  rst              in   1        synchronous, active-high reset
//  i_tag            in   TAG_W    miss address tag
//  i_index          in   INDEX_W  miss address index
//  i_offset         in   OFFSET_W miss address offset
//  i_cache_miss     in   1        level; sa_cache holds it high until the response
//  i_evict          in   1        one-cycle pulse: push {i_evict_addr, i_evict_data}
//  i_evict_addr     in   ADDR_W   eviction address
//  i_evict_data     in   DATA_W   eviction data
//  o_memory_line    out  DATA_W   fill data; valid with o_memory_response
//  o_memory_response out 1        one-cycle fill-done pulse
//  o_mem_req        out  1        memory request, held until acked
//  o_mem_we         out  1        1=write, 0=read
//  o_mem_addr       out  ADDR_W   memory address
//  o_mem_wdata      out  DATA_W   memory write data
//  i_mem_ack        in   1        one-cycle acknowledge; i_mem_rdata valid on read ack
//  i_mem_rdata      in   DATA_W   memory read data
//  o_wb_count       out  $clog2(WB_DEPTH+1)  FIFO occupancy
//  o_wb_full        out  1        o_wb_count==WB_DEPTH
//  o_wb_overflow    out  1        sticky; set on a dropped eviction
// BEHAVIOUR
//  Reset: every output is 0; FIFO is emptied; FSM enters IDLE.
//  Reset mid-transaction: the outstanding request is abandoned.
//    o_mem_req is low in the first cycle after rst is sampled.
//  Miss address = {i_tag,i_index,i_offset}. Address compares use [ADDR_W-1:2].
//  FIFO push rules:
//    - i_evict while not full: pushed.
//    - i_evict while full: pushed only if a write ack pops the head in the
//      same cycle; otherwise dropped and o_wb_overflow sets.
//    - Simultaneous push and pop: count unchanged.
//  Memory handshake: o_mem_addr, o_mem_we and o_mem_wdata are stable while
//    o_mem_req=1. Request drops in the cycle after ack is sampled.
//  FSM states:
//   IDLE:
//     - Miss pending and FIFO empty -> READ.
//     - FIFO non-empty (miss or not) -> WRITE on FIFO head.
//   WRITE:
//     - o_mem_req=1, o_mem_we=1.
//     - On ack: pop the head -> IDLE.
//   READ:
//     - o_mem_req=1, o_mem_we=0.
//     - On ack: capture i_mem_rdata -> RESP.
//   RESP:
//     - o_memory_response=1 for exactly one cycle, o_memory_line=captured
//       data -> HOLD.
//   HOLD:
//     - Wait for i_cache_miss=0, then -> IDLE.
//     - Prevents a still-high miss from being served twice.
//  Ordering: all writes buffered before a miss drain before that miss's read.
//    A read never bypasses an older write.
//  Read latency: miss seen in IDLE at cycle N with FIFO empty ->
//    o_mem_req=1 at N+1; ack at cycle M -> o_memory_response at M+1.
//  Evictions keep being accepted in every state, including READ, RESP and HOLD.
// CONFIGURATION
//  SA_CACHE_WB_FWD_EN defined:
//    - In IDLE, the miss address is compared against all valid FIFO entries
//      plus the same-cycle i_evict.
//    - On a match, the youngest matching entry is forwarded: RESP is entered
//      at N+1 with no memory read.
//    - On no match, READ is entered immediately and bypasses buffered writes.
//    - The FIFO drains only while no miss is pending.
//  SA_CACHE_WB_FWD_EN undefined: no comparators; ordering rule above applies.
// TESTING
//  1. Reset: rst=1 for 2 cycles mid-READ -> o_mem_req=0 the next cycle,
//     o_wb_count=0, all outputs 0.
//  2. Clean miss: addr 0x0000_1240, FIFO empty, ack 3 cycles after req with
//     rdata 0xDEAD_BEEF -> read of 0x0000_1240; response pulse 1 cycle after
//     ack, line=0xDEAD_BEEF.
//  3. Evict then miss: evict (0x0000_2000, 0x1111_1111), then miss 0x0000_3000
//     -> write 0x0000_2000 acked before read 0x0000_3000 issues (FWD off).
//  4. FWD on: evict (0x0000_4000, 0xCAFE_F00D), then miss 0x0000_4000 ->
//     o_memory_response=1 with 0xCAFE_F00D, o_mem_req stays 0.
//  5. Fill FIFO: 4 evicts, memory stalls -> o_wb_full=1.
//     5th evict -> o_wb_overflow=1, count stays 4.
//     5th evict in the same cycle as a write ack -> accepted, count stays 4.
//  6. Handshake: miss held high 5 cycles after response -> exactly one
//     response pulse; no second read.

Source files
------------

// File: rtl/sa_cache_mem_ctrl.sv
// sa_cache_mem_ctrl: memory-side companion of sa_cache.
// Buffers evictions in a write-back FIFO, drains them to backing memory and
// serves cache misses with a req/ack read, returning the line as a
// one-cycle response pulse.
// Optional feature macro: SA_CACHE_WB_FWD_EN. It forwards a miss from a
// matching buffered eviction, and lets reads bypass buffered writes.
module sa_cache_mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 18,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 6,
  parameter int WB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TAG_W-1:0]              i_tag,
  input  logic [INDEX_W-1:0]            i_index,
  input  logic [OFFSET_W-1:0]           i_offset,
  input  logic                          i_cache_miss,
  input  logic                          i_evict,
  input  logic [ADDR_W-1:0]             i_evict_addr,
  input  logic [DATA_W-1:0]             i_evict_data,
  output logic [DATA_W-1:0]             o_memory_line,
  output logic                          o_memory_response,
  output logic                          o_mem_req,
  output logic                          o_mem_we,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [DATA_W-1:0]             o_mem_wdata,
  input  logic                          i_mem_ack,
  input  logic [DATA_W-1:0]             i_mem_rdata,
  output logic [$clog2(WB_DEPTH+1)-1:0] o_wb_count,
  output logic                          o_wb_full,
  output logic                          o_wb_overflow
);

  localparam int CNT_W = $clog2(WB_DEPTH + 1);
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP,
    ST_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] miss_addr;
  assign miss_addr = {i_tag, i_index, i_offset};

  logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
  logic [ADDR_W-1:0] wb_addr_d [WB_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
  logic [DATA_W-1:0] wb_data_d [WB_DEPTH];
  logic [PTR_W-1:0]  wb_head_q, wb_head_d;
  logic [PTR_W-1:0]  wb_tail_q, wb_tail_d;
  logic [CNT_W-1:0]  wb_count_q, wb_count_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] line_q, line_d;
  logic              wb_full, wb_pop, wb_push;

  assign wb_full = (wb_count_q == FULL_CNT);

`ifdef SA_CACHE_WB_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  // Youngest matching entry wins: scan oldest to youngest, then the same-cycle eviction.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      if ((CNT_W'(i) < wb_count_q) &&
          (wb_addr_q[wb_head_q + PTR_W'(i)][ADDR_W-1:2] == miss_addr[ADDR_W-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[wb_head_q + PTR_W'(i)];
      end
    end
    if (i_evict && (i_evict_addr[ADDR_W-1:2] == miss_addr[ADDR_W-1:2])) begin
      fwd_hit  = 1'b1;
      fwd_data = i_evict_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef SA_CACHE_WB_FWD_EN
        // A pending miss takes priority; the FIFO drains only when no miss waits.
        if (i_cache_miss)             state_d = fwd_hit ? ST_RESP : ST_READ;
        else if (wb_count_q != '0)    state_d = ST_WRITE;
`else
        // Buffered writes always drain first so a read never passes an older write.
        if (wb_count_q != '0)         state_d = ST_WRITE;
        else if (i_cache_miss)        state_d = ST_READ;
`endif
      end
      ST_WRITE: if (i_mem_ack)     state_d = ST_IDLE;
      ST_READ:  if (i_mem_ack)     state_d = ST_RESP;
      ST_RESP:                     state_d = ST_HOLD;
      ST_HOLD:  if (!i_cache_miss) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping, overflow flag, read address and fill-line capture.
  always_comb begin
    wb_pop     = (state_q == ST_WRITE) && i_mem_ack;
    wb_push    = i_evict && (!wb_full || wb_pop);
    wb_head_d  = wb_pop  ? wb_head_q + PTR_W'(1) : wb_head_q;
    wb_tail_d  = wb_push ? wb_tail_q + PTR_W'(1) : wb_tail_q;
    wb_count_d = wb_count_q;
    if (wb_push && !wb_pop)      wb_count_d = wb_count_q + CNT_W'(1);
    else if (!wb_push && wb_pop) wb_count_d = wb_count_q - CNT_W'(1);
    ovf_d      = ovf_q | (i_evict & ~wb_push);
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    if (wb_push) begin
      wb_addr_d[wb_tail_q] = i_evict_addr;
      wb_data_d[wb_tail_q] = i_evict_data;
    end
    rd_addr_d = rd_addr_q;
    if ((state_q == ST_IDLE) && (state_d == ST_READ)) rd_addr_d = miss_addr;
    line_d = line_q;
    if ((state_q == ST_READ) && i_mem_ack) line_d = i_mem_rdata;
`ifdef SA_CACHE_WB_FWD_EN
    if ((state_q == ST_IDLE) && (state_d == ST_RESP)) line_d = fwd_data;
`endif
  end

  // Datapath registers with reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_head_q  <= '0;
      wb_tail_q  <= '0;
      wb_count_q <= '0;
      ovf_q      <= 1'b0;
      rd_addr_q  <= '0;
      line_q     <= '0;
    end else begin
      wb_head_q  <= wb_head_d;
      wb_tail_q  <= wb_tail_d;
      wb_count_q <= wb_count_d;
      ovf_q      <= ovf_d;
      rd_addr_q  <= rd_addr_d;
      line_q     <= line_d;
    end
  end

  // FIFO storage; contents are meaningless outside the valid window so no reset.
  always_ff @(posedge clk) begin
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
  end

  // Outputs decoded from state; request fields come from registers so they stay stable.
  always_comb begin
    o_mem_req         = 1'b0;
    o_mem_we          = 1'b0;
    o_mem_addr        = '0;
    o_mem_wdata       = '0;
    o_memory_response = 1'b0;
    o_memory_line     = '0;
    case (state_q)
      ST_WRITE: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = wb_addr_q[wb_head_q];
        o_mem_wdata = wb_data_q[wb_head_q];
      end
      ST_READ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = rd_addr_q;
      end
      ST_RESP: begin
        o_memory_response = 1'b1;
        o_memory_line     = line_q;
      end
      default: ;
    endcase
    o_wb_count    = wb_count_q;
    o_wb_full     = wb_full;
    o_wb_overflow = ovf_q;
  end

endmodule

// File: tb/tb_sa_cache_mem_ctrl.sv
// Self-checking bench for sa_cache_mem_ctrl: directed sequences, a FIFO
// vector table and a randomized phase checked against a queue-based model.
module tb_sa_cache_mem_ctrl;
  localparam int ADDR_W = 32, DATA_W = 32, TAG_W = 18, INDEX_W = 8, OFFSET_W = 6, WB_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [TAG_W-1:0] i_tag;
  logic [INDEX_W-1:0] i_index;
  logic [OFFSET_W-1:0] i_offset;
  logic i_cache_miss, i_evict, i_mem_ack;
  logic [ADDR_W-1:0] i_evict_addr, miss_addr;
  logic [DATA_W-1:0] i_evict_data, i_mem_rdata;
  logic [DATA_W-1:0] o_memory_line, o_mem_wdata;
  logic o_memory_response, o_mem_req, o_mem_we, o_wb_full, o_wb_overflow;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [$clog2(WB_DEPTH+1)-1:0] o_wb_count;

  assign {i_tag, i_index, i_offset} = miss_addr;

  sa_cache_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .INDEX_W(INDEX_W),
                      .OFFSET_W(OFFSET_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk(clk), .rst(rst), .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
    .i_cache_miss(i_cache_miss), .i_evict(i_evict), .i_evict_addr(i_evict_addr),
    .i_evict_data(i_evict_data), .o_memory_line(o_memory_line),
    .o_memory_response(o_memory_response), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_wb_count(o_wb_count), .o_wb_full(o_wb_full),
    .o_wb_overflow(o_wb_overflow));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req"}, 64'(o_mem_req), 0);
    chk({tag, " we"}, 64'(o_mem_we), 0);
    chk({tag, " addr"}, 64'(o_mem_addr), 0);
    chk({tag, " wdata"}, 64'(o_mem_wdata), 0);
    chk({tag, " resp"}, 64'(o_memory_response), 0);
    chk({tag, " line"}, 64'(o_memory_line), 0);
    chk({tag, " count"}, 64'(o_wb_count), 0);
    chk({tag, " full"}, 64'(o_wb_full), 0);
    chk({tag, " ovf"}, 64'(o_wb_overflow), 0);
  endtask

  typedef struct {
    logic        evict;
    logic        ack;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cnt;
    logic        full;
    logic        ovf;
    logic        req;
    logic [31:0] maddr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wb_ent_t;

  vec_t tbl[8];
  logic [31:0] drain_addr[4];
  logic [31:0] drain_data[4];

  initial begin
    rst = 1'b1; i_cache_miss = 0; i_evict = 0; i_mem_ack = 0;
    i_evict_addr = '0; i_evict_data = '0; i_mem_rdata = '0; miss_addr = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Clean miss, ack three cycles after the request, then miss held after response.
    miss_addr = 32'h0000_1240; i_cache_miss = 1;
    @(negedge clk);
    chk("t2 req at N+1", 64'(o_mem_req), 1);
    chk("t2 we", 64'(o_mem_we), 0);
    chk("t2 addr", 64'(o_mem_addr), 64'h1240);
    repeat (2) begin
      @(negedge clk);
      chk("t2 req held", 64'(o_mem_req), 1);
      chk("t2 addr stable", 64'(o_mem_addr), 64'h1240);
    end
    i_mem_ack = 1; i_mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    i_mem_ack = 0;
    chk("t2 resp", 64'(o_memory_response), 1);
    chk("t2 line", 64'(o_memory_line), 64'hDEAD_BEEF);
    chk("t2 req dropped", 64'(o_mem_req), 0);
    repeat (5) begin
      @(negedge clk);
      chk("t6 no second resp", 64'(o_memory_response), 0);
      chk("t6 no second read", 64'(o_mem_req), 0);
    end
    i_cache_miss = 0;
    repeat (2) @(negedge clk);
    chk("t6 idle after drop", 64'(o_mem_req), 0);

`ifndef SA_CACHE_WB_FWD_EN
    // Evict then miss: the write must complete before the read issues.
    i_evict = 1; i_evict_addr = 32'h0000_2000; i_evict_data = 32'h1111_1111;
    @(negedge clk);
    i_evict = 0;
    chk("t3 count", 64'(o_wb_count), 1);
    miss_addr = 32'h0000_3000; i_cache_miss = 1;
    @(negedge clk);
    chk("t3 write req", 64'(o_mem_req), 1);
    chk("t3 write we", 64'(o_mem_we), 1);
    chk("t3 write addr", 64'(o_mem_addr), 64'h2000);
    chk("t3 write data", 64'(o_mem_wdata), 64'h1111_1111);
    i_mem_ack = 1;
    @(negedge clk);
    i_mem_ack = 0;
    chk("t3 req drop", 64'(o_mem_req), 0);
    chk("t3 count drained", 64'(o_wb_count), 0);
    @(negedge clk);
    chk("t3 read req", 64'(o_mem_req), 1);
    chk("t3 read we", 64'(o_mem_we), 0);
    chk("t3 read addr", 64'(o_mem_addr), 64'h3000);
    i_mem_ack = 1; i_mem_rdata = 32'h3333_3333;
    @(negedge clk);
    i_mem_ack = 0;
    chk("t3 resp", 64'(o_memory_response), 1);
    chk("t3 line", 64'(o_memory_line), 64'h3333_3333);
    i_cache_miss = 0;
    repeat (2) @(negedge clk);
`endif

    // Evict then miss to the same address.
    i_evict = 1; i_evict_addr = 32'h0000_4000; i_evict_data = 32'hCAFE_F00D;
    @(negedge clk);
    i_evict = 0; miss_addr = 32'h0000_4000; i_cache_miss = 1;
    @(negedge clk);
`ifdef SA_CACHE_WB_FWD_EN
    chk("t4 fwd resp", 64'(o_memory_response), 1);
    chk("t4 fwd line", 64'(o_memory_line), 64'hCAFE_F00D);
    chk("t4 fwd no req", 64'(o_mem_req), 0);
    i_cache_miss = 0;
    @(negedge clk);
    chk("t4 fwd hold no req", 64'(o_mem_req), 0);
    repeat (2) @(negedge clk);
    chk("t4 drain write", 64'(o_mem_we), 1);
    i_mem_ack = 1;
    @(negedge clk);
    i_mem_ack = 0;
    chk("t4 drained", 64'(o_wb_count), 0);
`else
    chk("t4 write first", 64'(o_mem_we), 1);
    chk("t4 write addr", 64'(o_mem_addr), 64'h4000);
    chk("t4 write data", 64'(o_mem_wdata), 64'hCAFE_F00D);
    i_mem_ack = 1;
    @(negedge clk);
    i_mem_ack = 0;
    @(negedge clk);
    chk("t4 read req", 64'(o_mem_req), 1);
    chk("t4 read we", 64'(o_mem_we), 0);
    i_mem_ack = 1; i_mem_rdata = 32'h4444_4444;
    @(negedge clk);
    i_mem_ack = 0;
    chk("t4 resp line", 64'(o_memory_line), 64'h4444_4444);
    i_cache_miss = 0;
    repeat (2) @(negedge clk);
`endif

    // FIFO fill / overflow / push-at-full-with-pop table; memory stalls until row 6.
    tbl[0] = '{1'b1, 1'b0, 32'h100, 32'hD0, 1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h200, 32'hD1, 2, 1'b0, 1'b0, 1'b1, 32'h100};
    tbl[2] = '{1'b1, 1'b0, 32'h300, 32'hD2, 3, 1'b0, 1'b0, 1'b1, 32'h100};
    tbl[3] = '{1'b1, 1'b0, 32'h400, 32'hD3, 4, 1'b1, 1'b0, 1'b1, 32'h100};
    tbl[4] = '{1'b1, 1'b0, 32'h500, 32'hD4, 4, 1'b1, 1'b1, 1'b1, 32'h100};
    tbl[5] = '{1'b0, 1'b0, 32'h0,   32'h0,  4, 1'b1, 1'b1, 1'b1, 32'h100};
    tbl[6] = '{1'b1, 1'b1, 32'h600, 32'hD5, 4, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b0, 32'h0,   32'h0,  4, 1'b1, 1'b1, 1'b1, 32'h200};
    for (int i = 0; i < 8; i++) begin
      i_evict = tbl[i].evict; i_evict_addr = tbl[i].addr; i_evict_data = tbl[i].data;
      i_mem_ack = tbl[i].ack;
      @(negedge clk);
      i_evict = 0; i_mem_ack = 0;
      chk($sformatf("t5 row%0d count", i), 64'(o_wb_count), 64'(tbl[i].cnt));
      chk($sformatf("t5 row%0d full", i), 64'(o_wb_full), 64'(tbl[i].full));
      chk($sformatf("t5 row%0d ovf", i), 64'(o_wb_overflow), 64'(tbl[i].ovf));
      chk($sformatf("t5 row%0d req", i), 64'(o_mem_req), 64'(tbl[i].req));
      chk($sformatf("t5 row%0d addr", i), 64'(o_mem_addr), 64'(tbl[i].maddr));
    end
    drain_addr = '{32'h200, 32'h300, 32'h400, 32'h600};
    drain_data = '{32'hD1, 32'hD2, 32'hD3, 32'hD5};
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t5 drain%0d addr", j), 64'(o_mem_addr), 64'(drain_addr[j]));
      chk($sformatf("t5 drain%0d data", j), 64'(o_mem_wdata), 64'(drain_data[j]));
      i_mem_ack = 1;
      @(negedge clk);
      i_mem_ack = 0;
      chk($sformatf("t5 drain%0d count", j), 64'(o_wb_count), 64'(3 - j));
      if (j < 3) @(negedge clk);
    end

    // Reset in the middle of a read, with an eviction accepted during READ.
    miss_addr = 32'h0000_7000; i_cache_miss = 1;
    i_evict = 1; i_evict_addr = 32'h0000_8000; i_evict_data = 32'h8888_8888;
    @(negedge clk);
    i_evict = 0;
    chk("t1 in read", 64'(o_mem_req), 1);
    chk("t1 read we", 64'(o_mem_we), 0);
    chk("t1 evict accepted in read", 64'(o_wb_count), 1);
    rst = 1; i_cache_miss = 0;
    @(negedge clk);
    chk_all_zero("t1 reset mid-read");
    @(negedge clk);
    rst = 0;

`ifndef SA_CACHE_WB_FWD_EN
    begin : random_phase
      wb_ent_t q[$];
      wb_ent_t ent;
      bit ovf_m = 0, miss_on = 0, resp_seen = 0, resp_due = 0, req_prev = 0, ack_prev = 0;
      bit order_ok;
      int hold_left = 0, low_cnt = 2, reads = 0, miss_start = 0, age = 0, ack_wait = 0;
      logic [31:0] due_line = '0, st_addr = '0, st_wdata = '0;
      logic st_we = 0;
      for (int it = 0; it < 4000; it++) begin
        @(negedge clk);
        chk("r count", 64'(o_wb_count), 64'(q.size()));
        chk("r full", 64'(o_wb_full), 64'(q.size() == WB_DEPTH));
        chk("r ovf", 64'(o_wb_overflow), 64'(ovf_m));
        chk("r resp", 64'(o_memory_response), 64'(resp_due));
        if (resp_due) begin
          chk("r line", 64'(o_memory_line), 64'(due_line));
          resp_seen = 1; hold_left = $urandom_range(0, 4);
        end
        if (ack_prev) chk("r req drops after ack", 64'(o_mem_req), 0);
        if (o_mem_req && !req_prev) begin
          st_addr = o_mem_addr; st_we = o_mem_we; st_wdata = o_mem_wdata;
          ack_wait = $urandom_range(0, 3);
          if (o_mem_we) begin
            if (q.size() == 0) chk("r write with empty fifo", 1, 0);
            else begin
              chk("r write addr", 64'(o_mem_addr), 64'(q[0].addr));
              chk("r write data", 64'(o_mem_wdata), 64'(q[0].data));
            end
          end else begin
            reads++;
            chk("r read only for pending miss", 64'(miss_on && !resp_seen), 1);
            chk("r one read per miss", 64'(reads), 1);
            chk("r read addr", 64'(o_mem_addr), 64'(miss_addr));
            order_ok = 1;
            foreach (q[k]) if (q[k].cyc < miss_start) order_ok = 0;
            chk("r read after older writes", 64'(order_ok), 1);
          end
        end else if (o_mem_req) begin
          chk("r req fields stable", {o_mem_addr, o_mem_wdata}, {st_addr, st_wdata});
          chk("r req we stable", 64'(o_mem_we), 64'(st_we));
        end
        if (miss_on && !resp_seen) begin
          age++;
          if (age == 400) chk("r miss served within budget", 0, 1);
        end
        req_prev = o_mem_req;

        // Inputs for the next edge.
        resp_due = 0;
        i_mem_ack = 0;
        if (o_mem_req) begin
          if (ack_wait == 0) begin
            i_mem_ack = 1; i_mem_rdata = $urandom;
            if (!o_mem_we) begin resp_due = 1; due_line = i_mem_rdata; end
          end else ack_wait--;
        end
        ack_prev = i_mem_ack;
        if (!miss_on) begin
          low_cnt++;
          if (low_cnt >= 2 && $urandom_range(0, 3) == 0) begin
            miss_on = 1; miss_addr = $urandom; miss_start = it;
            reads = 0; resp_seen = 0; age = 0;
          end
        end else if (resp_seen && !resp_due) begin
          if (hold_left == 0) begin miss_on = 0; low_cnt = 0; end
          else hold_left--;
        end
        i_cache_miss = miss_on;
        i_evict = ($urandom_range(0, 7) == 0);
        i_evict_addr = $urandom; i_evict_data = $urandom;

        // Model: pop on write ack, then push if room remains, else the eviction is lost.
        if (i_mem_ack && o_mem_we && q.size() != 0) void'(q.pop_front());
        if (i_evict) begin
          if (q.size() < WB_DEPTH) begin
            ent.addr = i_evict_addr; ent.data = i_evict_data; ent.cyc = it;
            q.push_back(ent);
          end else ovf_m = 1;
        end
      end
      i_evict = 0; i_mem_ack = 0; i_cache_miss = 0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
